apb_slave_bank: RTL and testbench
=================================

# apb_slave_bank

Three-slave APB register bank that sits directly downstream of the AHB-to-APB bridge. It consumes the bridge's APB outputs (`Pselx`, `Paddr`, `Pwrite`, `Penable`, `Pwdata`) and returns `Prdata`. Each `Pselx` bit selects one bank of `DEPTH` 32-bit words. The block also keeps saturating transfer counters and, optionally, an APB protocol checker, so bridge regressions get a self-checking endpoint.

## Interface
- `DEPTH`, 16: words per slave bank; must be a power of 2, at least 2.
- `RESET_VAL`, 32'h0000_0000: reset contents of every word.
- `Pclk` input 1: APB clock; the only clock in the block.
- `Preset` input 1: asynchronous, active-high reset.
- `Pselx` input 3: one-hot slave select; bit k selects bank k.
- `Penable` input 1: APB access phase.
- `Pwrite` input 1: 1 = write, 0 = read.
- `Paddr` input 32: byte address; the word index is `Paddr[2 +: $clog2(DEPTH)]`.
- `Pwdata` input 32: write data.
- `Prdata` output 32: read data, registered.
- `wr_cnt` output 16: completed writes; saturates at 16'hFFFF.
- `rd_cnt` output 16: completed reads; saturates at 16'hFFFF.
- `prot_err` output 1: sticky protocol-error flag.
- `prot_err_cnt` output 8: protocol-error count; saturates at 8'hFF.

## Operation
- FSM, registered, tracks the APB phase sampled at each `Pclk` rising edge:
  - IDLE: `Pselx`==0.
  - SETUP: `Pselx`!=0 and `Penable`=0.
  - ACCESS: `Pselx`!=0 and `Penable`=1.
  - Legal transitions: IDLE→SETUP; SETUP→ACCESS; ACCESS→IDLE; ACCESS→SETUP (back-to-back transfer).
  - Any other observed phase is recorded in the state as-is. It is flagged only by the checker.
- Read: at the edge that samples SETUP with `Pwrite`=0, `Prdata` ← `bank[k][idx]`.
  - `Prdata` holds that value until the next read setup.
  - `rd_cnt` increments at the ACCESS edge of the read.
- Write: at the edge that samples ACCESS with `Pwrite`=1, `bank[k][idx]` ← `Pwdata` and `wr_cnt` increments.
  - The write uses the address and data present in ACCESS.
- Multi-hot `Pselx` (more than one bit set):
  - No write.
  - A read loads `Prdata` ← 32'h0.
  - No counter increments.
  - This holds with or without the checker.
- Address handling:
  - Upper address bits above the index alias.
  - `Paddr[1:0]` is ignored for data; the checker flags it when nonzero.
- `Penable`=1 seen in state IDLE (access without setup): no write, no counter update, `Prdata` unchanged.

## Timing
- Reset values: `Prdata`=0; `wr_cnt`=0; `rd_cnt`=0; `prot_err`=0; `prot_err_cnt`=0; FSM=IDLE; every word=`RESET_VAL`.
- Reset is asynchronous. Asserting `Preset` mid-transfer drops the in-flight write and clears everything immediately.
- Read latency: `Prdata` is valid from the first cycle of the access phase, i.e. one `Pclk` after setup is sampled.
- Write latency: the new value is visible to a read whose setup is sampled on the edge after the write's ACCESS edge.
- Back-to-back read after write to the same word returns the new data.
- Counters saturate and never wrap. A write and a read cannot complete on the same edge.

## Configuration
- `APB_SLV_PROT_CHECK_EN` defined: checker instantiated. On each error edge, `prot_err` is set (sticky until reset) and `prot_err_cnt` increments once. Errors:
  - (a) `Penable`=1 while state≠SETUP and state≠ACCESS.
  - (b) `Paddr`, `Pwrite`, `Pwdata` or `Pselx` differs between SETUP and the following ACCESS.
  - (c) multi-hot `Pselx`.
  - (d) `Paddr[1:0]`≠0 during SETUP.
  - (e) SETUP followed by anything other than ACCESS.
  - Several errors on one edge count once.
- `APB_SLV_PROT_CHECK_EN` undefined: `prot_err` and `prot_err_cnt` are tied to 0. All data behaviour is identical.

## Structure
- Package `apb_slv_pkg` holds:
  - the phase enum (IDLE/SETUP/ACCESS);
  - `NUM_SLV`=3;
  - `CNT_W`=16;
  - `ERR_CNT_W`=8;
  - the error-cause bit positions.
- Sub-module `apb_slv_prot_chk` holds:
  - the SETUP snapshot registers;
  - the error detection;
  - the sticky flag and error counter.
- The sub-module is instantiated only under the macro.

## Test plan
- Reset, then read bank 0 word 1 (`Pselx`=001, `Paddr`=32'h8000_0004) → `Prdata`=32'h0 in the access cycle; `rd_cnt`=1.
- Write 32'hA5A5_5A5A to bank 1 word 3 (`Pselx`=010, `Paddr`=0x0C), then read the same word back-to-back → `Prdata`=32'hA5A5_5A5A; `wr_cnt`=1; `rd_cnt`=1; bank 0 word 3 is still 0.
- Write with `Pselx`=011 → no bank changes; `wr_cnt` stays 0; with the macro, `prot_err`=1 and `prot_err_cnt`=1.
- `Paddr` changes from 0x04 to 0x08 between SETUP and ACCESS of a write → data lands at 0x08; with the macro, the error count is +1; without it, `prot_err`=0.
- Run 65 540 writes → `wr_cnt` holds at 16'hFFFF.
- Assert `Preset` during the ACCESS of a write of 32'hDEAD_DEAD → the word reads back `RESET_VAL`; all counters are 0.

Source files
------------

// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the three-slave APB register bank.
// Imported by the bus interface, the protocol checker and the top level.
package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_phase_e;

  localparam int NUM_SLV   = 3;
  localparam int CNT_W     = 16;
  localparam int ERR_CNT_W = 8;

  localparam int ERR_EN_NO_SETUP = 0;
  localparam int ERR_UNSTABLE    = 1;
  localparam int ERR_MULTI_SEL   = 2;
  localparam int ERR_MISALIGN    = 3;
  localparam int ERR_NO_ACCESS   = 4;
  localparam int ERR_NUM         = 5;

  function automatic apb_phase_e phaseOf(input logic [NUM_SLV-1:0] sel, input logic en);
    if (sel == '0) return IDLE;
    return en ? ACCESS : SETUP;
  endfunction

  function automatic logic isOneHot(input logic [NUM_SLV-1:0] sel);
    return $onehot(sel);
  endfunction

endpackage

// File: rtl/apb_slave_bank_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and the register bank (slave).
interface apb_slave_bank_if;
  import apb_slv_pkg::*;

  logic [NUM_SLV-1:0] Pselx;
  logic               Penable;
  logic               Pwrite;
  logic [31:0]        Paddr;
  logic [31:0]        Pwdata;
  logic [31:0]        Prdata;

  modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata);
  modport slave  (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata);

endinterface

// File: rtl/apb_slv_prot_chk.sv
// APB protocol checker: snapshots SETUP, flags protocol violations, keeps a sticky
// flag and a saturating error count. Only built when APB_SLV_PROT_CHECK_EN is defined.
module apb_slv_prot_chk
  import apb_slv_pkg::*;
(
  input  logic                 Pclk,
  input  logic                 Preset,
  input  apb_phase_e           state_i,
  input  apb_phase_e           phase_i,
  input  logic [NUM_SLV-1:0]   sel_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 protErr_o,
  output logic [ERR_CNT_W-1:0] protErrCnt_o
);

  logic [NUM_SLV-1:0]   snapSel_q;
  logic                 snapWrite_q;
  logic [31:0]          snapAddr_q;
  logic [31:0]          snapWdata_q;
  logic                 protErr_q;
  logic [ERR_CNT_W-1:0] errCnt_q;
  logic [ERR_NUM-1:0]   errVec;
  logic                 anyErr;

  // Select checks run on SETUP only, so a multi-hot transfer is counted once.
  always_comb begin
    errVec                  = '0;
    errVec[ERR_EN_NO_SETUP] = enable_i && (state_i == IDLE);
    errVec[ERR_UNSTABLE]    = (state_i == SETUP) && (phase_i == ACCESS) &&
                              ({sel_i, write_i, addr_i, wdata_i} !=
                               {snapSel_q, snapWrite_q, snapAddr_q, snapWdata_q});
    errVec[ERR_MULTI_SEL]   = (phase_i == SETUP) && !isOneHot(sel_i);
    errVec[ERR_MISALIGN]    = (phase_i == SETUP) && (addr_i[1:0] != 2'b00);
    errVec[ERR_NO_ACCESS]   = (state_i == SETUP) && (phase_i != ACCESS);
    anyErr                  = |errVec;
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      snapSel_q   <= '0;
      snapWrite_q <= 1'b0;
      snapAddr_q  <= '0;
      snapWdata_q <= '0;
      protErr_q   <= 1'b0;
      errCnt_q    <= '0;
    end else begin
      if (phase_i == SETUP) begin
        snapSel_q   <= sel_i;
        snapWrite_q <= write_i;
        snapAddr_q  <= addr_i;
        snapWdata_q <= wdata_i;
      end
      if (anyErr) begin
        protErr_q <= 1'b1;
        if (errCnt_q != '1) errCnt_q <= errCnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign protErr_o    = protErr_q;
  assign protErrCnt_o = errCnt_q;

endmodule

// File: rtl/apb_slave_bank.sv
// Three-slave APB register bank with saturating transfer counters.
// Define APB_SLV_PROT_CHECK_EN to build in the APB protocol checker.
module apb_slave_bank
  import apb_slv_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                 Pclk,
  input  logic                 Preset,
  apb_slave_bank_if.slave      apb,
  output logic [CNT_W-1:0]     wr_cnt,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic                 prot_err,
  output logic [ERR_CNT_W-1:0] prot_err_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  apb_phase_e       state_q, phase_d;
  logic [31:0]      rdData_q, rdData_d;
  logic [CNT_W-1:0] wrCnt_q, wrCnt_d, rdCnt_q, rdCnt_d;
  logic [31:0]      bank_q [NUM_SLV][DEPTH];
  logic [IDX_W-1:0] wordIdx;
  logic [31:0]      selWord;
  logic             oneHot, xferDone, wrDone, rdDone, rdSetup;
  logic             unusedAddr;

  assign unusedAddr = ^{apb.Paddr[31:2+IDX_W], apb.Paddr[1:0]};

  // An ACCESS straight out of IDLE never completes a transfer.
  always_comb begin
    wordIdx  = apb.Paddr[2 +: IDX_W];
    oneHot   = isOneHot(apb.Pselx);
    phase_d  = phaseOf(apb.Pselx, apb.Penable);
    xferDone = (phase_d == ACCESS) && (state_q != IDLE) && oneHot;
    wrDone   = xferDone && apb.Pwrite;
    rdDone   = xferDone && !apb.Pwrite;
    rdSetup  = (phase_d == SETUP) && !apb.Pwrite;
    selWord  = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (apb.Pselx[k]) selWord = bank_q[k][wordIdx];
    end
    rdData_d = rdData_q;
    if (rdSetup) rdData_d = oneHot ? selWord : 32'h0;
    wrCnt_d = (wrDone && wrCnt_q != '1) ? wrCnt_q + CNT_W'(1) : wrCnt_q;
    rdCnt_d = (rdDone && rdCnt_q != '1) ? rdCnt_q + CNT_W'(1) : rdCnt_q;
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      state_q  <= IDLE;
      rdData_q <= '0;
      wrCnt_q  <= '0;
      rdCnt_q  <= '0;
    end else begin
      state_q  <= phase_d;
      rdData_q <= rdData_d;
      wrCnt_q  <= wrCnt_d;
      rdCnt_q  <= rdCnt_d;
    end
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      for (int k = 0; k < NUM_SLV; k++) begin
        for (int w = 0; w < int'(DEPTH); w++) bank_q[k][w] <= RESET_VAL;
      end
    end else if (wrDone) begin
      for (int k = 0; k < NUM_SLV; k++) begin
        if (apb.Pselx[k]) bank_q[k][wordIdx] <= apb.Pwdata;
      end
    end
  end

  assign apb.Prdata = rdData_q;
  assign wr_cnt     = wrCnt_q;
  assign rd_cnt     = rdCnt_q;

`ifdef APB_SLV_PROT_CHECK_EN
  apb_slv_prot_chk u_prot_chk (
    .Pclk         (Pclk),
    .Preset       (Preset),
    .state_i      (state_q),
    .phase_i      (phase_d),
    .sel_i        (apb.Pselx),
    .enable_i     (apb.Penable),
    .write_i      (apb.Pwrite),
    .addr_i       (apb.Paddr),
    .wdata_i      (apb.Pwdata),
    .protErr_o    (prot_err),
    .protErrCnt_o (prot_err_cnt)
  );
`else
  assign prot_err     = 1'b0;
  assign prot_err_cnt = '0;
`endif

endmodule

// File: tb/tb_apb_slave_bank.sv
// Self-checking bench for apb_slave_bank: directed scenarios plus random APB traffic
// compared against an array-based model of the three banks and counters.
module tb_apb_slave_bank;
  import apb_slv_pkg::*;

  logic        Pclk = 1'b0;
  logic        Preset;
  logic [15:0] wrCnt, rdCnt;
  logic        protErr;
  logic [7:0]  protErrCnt;

  apb_slave_bank_if bus();

  apb_slave_bank #(.DEPTH(16), .RESET_VAL(32'h0000_0000)) dut (
    .Pclk         (Pclk),
    .Preset       (Preset),
    .apb          (bus.slave),
    .wr_cnt       (wrCnt),
    .rd_cnt       (rdCnt),
    .prot_err     (protErr),
    .prot_err_cnt (protErrCnt)
  );

  always #5 Pclk = ~Pclk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [3][16];
  int          expWr, expRd, expErr;
  bit          expFlag;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++) mem[k][w] = 32'h0;
    expWr = 0; expRd = 0; expErr = 0; expFlag = 0;
  endtask

  task automatic addProtErrors(input int n);
`ifdef APB_SLV_PROT_CHECK_EN
    if (n > 0) begin
      expFlag = 1;
      expErr  = (expErr + n > 255) ? 255 : expErr + n;
    end
`else
    if (n < 0) expFlag = 0;
`endif
  endtask

  function automatic logic [31:0] modelRead(input logic [2:0] sel, input logic [31:0] addr);
    logic [31:0] v;
    v = 32'h0;
    if ($countones(sel) == 1)
      for (int k = 0; k < 3; k++) if (sel[k]) v = mem[k][addr[5:2]];
    return v;
  endfunction

  task automatic modelTransfer(input logic [2:0] sel, input logic [31:0] setupAddr,
                               input logic [31:0] accessAddr, input logic wr, input logic [31:0] data);
    int n;
    if ($countones(sel) == 1) begin
      if (wr) begin
        for (int k = 0; k < 3; k++) if (sel[k]) mem[k][accessAddr[5:2]] = data;
        expWr = (expWr >= 65535) ? 65535 : expWr + 1;
      end else begin
        expRd = (expRd >= 65535) ? 65535 : expRd + 1;
      end
    end
    n = 0;
    if ($countones(sel) > 1 || setupAddr[1:0] != 2'b00) n++;
    if (setupAddr != accessAddr) n++;
    addProtErrors(n);
  endtask

  // Drives SETUP then ACCESS and leaves ACCESS on the bus, so a following call is back-to-back.
  task automatic applyStimulus(input string tag, input logic [2:0] sel, input logic [31:0] setupAddr,
                               input logic [31:0] accessAddr, input logic wr, input logic [31:0] data);
    logic [31:0] expRead;
    expRead = modelRead(sel, setupAddr);
    @(posedge Pclk); #1;
    bus.Pselx = sel; bus.Paddr = setupAddr; bus.Pwrite = wr; bus.Pwdata = data; bus.Penable = 1'b0;
    @(posedge Pclk); #1;
    if (!wr) checkOutput(tag, bus.Prdata, expRead);
    bus.Penable = 1'b1;
    bus.Paddr   = accessAddr;
    modelTransfer(sel, setupAddr, accessAddr, wr, data);
  endtask

  task automatic idleBus();
    @(posedge Pclk); #1;
    bus.Pselx = 3'b000; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_wrCnt"}, 32'(wrCnt), 32'(expWr));
    checkOutput({tag, "_rdCnt"}, 32'(rdCnt), 32'(expRd));
    checkOutput({tag, "_protErr"}, 32'(protErr), 32'(expFlag));
    checkOutput({tag, "_protErrCnt"}, 32'(protErrCnt), 32'(expErr));
  endtask

  initial begin
    logic [2:0]  sel;
    logic [31:0] addr;
    logic        wr;

    bus.Pselx = 3'b000; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
    bus.Paddr = 32'h0; bus.Pwdata = 32'h0;
    Preset = 1'b1;
    modelReset();
    repeat (2) @(posedge Pclk);
    #1 Preset = 1'b0;
    checkOutput("reset_Prdata", bus.Prdata, 32'h0);
    checkCounters("reset");

    applyStimulus("rd_b0w1", 3'b001, 32'h8000_0004, 32'h8000_0004, 1'b0, 32'h0);
    idleBus();
    checkOutput("rd_b0w1_rdCnt", 32'(rdCnt), 32'd1);
    checkCounters("rd_b0w1");

    applyStimulus("wr_b1w3", 3'b010, 32'h0000_000C, 32'h0000_000C, 1'b1, 32'hA5A5_5A5A);
    applyStimulus("rd_b1w3", 3'b010, 32'h0000_000C, 32'h0000_000C, 1'b0, 32'h0);
    idleBus();
    checkOutput("rd_b1w3_hold", bus.Prdata, 32'hA5A5_5A5A);
    checkOutput("wr_b1w3_wrCnt", 32'(wrCnt), 32'd1);
    applyStimulus("rd_b0w3", 3'b001, 32'h0000_000C, 32'h0000_000C, 1'b0, 32'h0);
    idleBus();
    checkCounters("b2b");

    applyStimulus("wr_multi", 3'b011, 32'h0000_0010, 32'h0000_0010, 1'b1, 32'h1111_2222);
    applyStimulus("rd_multi", 3'b011, 32'h0000_0010, 32'h0000_0010, 1'b0, 32'h0);
    applyStimulus("rd_b0w4", 3'b001, 32'h0000_0010, 32'h0000_0010, 1'b0, 32'h0);
    applyStimulus("rd_b1w4", 3'b010, 32'h0000_0010, 32'h0000_0010, 1'b0, 32'h0);
    idleBus();
    checkCounters("multi");

    applyStimulus("wr_addrchg", 3'b100, 32'h0000_0004, 32'h0000_0008, 1'b1, 32'hCAFE_F00D);
    idleBus();
    checkCounters("addrchg");
    applyStimulus("rd_b2w2", 3'b100, 32'h0000_0008, 32'h0000_0008, 1'b0, 32'h0);
    applyStimulus("rd_b2w1", 3'b100, 32'h0000_0004, 32'h0000_0004, 1'b0, 32'h0);
    idleBus();

    @(posedge Pclk); #1;
    bus.Pselx = 3'b001; bus.Penable = 1'b1; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h0000_0014; bus.Pwdata = 32'hBAD0_BAD0;
    idleBus();
    addProtErrors(1);
    checkCounters("noSetup");
    applyStimulus("rd_noSetup", 3'b001, 32'h0000_0014, 32'h0000_0014, 1'b0, 32'h0);
    idleBus();

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 8) sel = 3'(3'b001 << $urandom_range(0, 2));
      else sel = 3'(3 + $urandom_range(0, 3) * ($urandom_range(0, 1) + 1)) | 3'b001 << 0 & 3'b111;
      if ($countones(sel) < 2) sel = 3'b110;
      if ($urandom_range(0, 9) < 8) sel = 3'(3'b001 << $urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 9) != 0) addr[1:0] = 2'b00;
      wr = 1'($urandom_range(0, 1));
      applyStimulus("rand", sel, addr, addr, wr, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        idleBus();
        checkCounters("rand");
      end
    end
    idleBus();
    checkCounters("randEnd");

    @(posedge Pclk); #1;
    bus.Pselx = 3'b100; bus.Paddr = 32'h0000_003C; bus.Pwrite = 1'b1;
    bus.Pwdata = 32'h1234_5678; bus.Penable = 1'b0;
    @(posedge Pclk); #1;
    bus.Penable = 1'b1;
    repeat (65540) @(posedge Pclk);
    #1;
    bus.Pselx = 3'b000; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
    mem[2][15] = 32'h1234_5678;
    expWr = 65535;
    checkOutput("sat_wrCnt", 32'(wrCnt), 32'h0000_FFFF);
    checkCounters("sat");
    applyStimulus("rd_sat", 3'b100, 32'h0000_003C, 32'h0000_003C, 1'b0, 32'h0);
    idleBus();

    applyStimulus("wr_dead", 3'b001, 32'h0000_0008, 32'h0000_0008, 1'b1, 32'hDEAD_DEAD);
    #2 Preset = 1'b1;
    #1;
    modelReset();
    checkOutput("rstAsync_Prdata", bus.Prdata, 32'h0);
    checkCounters("rstAsync");
    @(posedge Pclk); #1;
    bus.Pselx = 3'b000; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
    @(posedge Pclk); #1;
    Preset = 1'b0;
    applyStimulus("rd_afterRst", 3'b001, 32'h0000_0008, 32'h0000_0008, 1'b0, 32'h0);
    idleBus();
    checkCounters("afterRst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
